// File: rtl/crc_sched_pkg.sv
// Shared types and defaults for the scheduled serial CRC engine.
// Holds the FSM state encoding, default CRC geometry and the counter-width helper.
// No ports; imported by crc_lfsr_serial and crc_serial_sched.
package crc_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int                    DEF_DATA_W = 10;
    localparam int                    DEF_CRC_W  = 3;
    // Low-order generator coefficients; x^CRC_W is implicit (x^3 + x + 1).
    localparam logic [DEF_CRC_W-1:0]  DEF_POLY   = 3'b011;
    localparam logic [DEF_CRC_W-1:0]  DEF_INIT   = 3'b000;

    // Bits needed to count 0..n-1; never less than one bit.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/crc_lfsr_serial.sv
// Bit-serial CRC LFSR: one message bit per enabled cycle, MSB first.
// Latency: register updates one edge after en/clr; no backpressure (pure datapath).
// Ports: clk, reset (async active-low), clr (load INIT), en (shift bit_in), crc (current remainder).
module crc_lfsr_serial
    import crc_sched_pkg::*;
#(
    parameter int               CRC_W = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY  = DEF_POLY,
    parameter logic [CRC_W-1:0] INIT  = DEF_INIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [CRC_W-1:0] crc
);

    logic [CRC_W-1:0] crc_q;
    logic [CRC_W-1:0] crc_d;
    logic             fb;

    always_comb begin
        fb    = crc_q[CRC_W-1] ^ bit_in;
        crc_d = crc_q;
        if (clr) begin
            crc_d = INIT;
        end else if (en) begin
            crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : {CRC_W{1'b0}});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/crc_serial_sched.sv
// Round-robin scheduler sharing one serial CRC LFSR between two requesters.
// Latency: crc_valid rises DATA_W edges after accept; one message per DATA_W+2 cycles back to back.
// Backpressure: result held in DONE until crc_ready; no new accept until the result is taken.
// Ports: s0_*/s1_* request valid/ready/data, crc_valid/crc_ready/crc_out/crc_src result, busy.
module crc_serial_sched
    import crc_sched_pkg::*;
#(
    parameter int               DATA_W = DEF_DATA_W,
    parameter int               CRC_W  = DEF_CRC_W,
    parameter logic [CRC_W-1:0] POLY   = DEF_POLY,
    parameter logic [CRC_W-1:0] INIT   = DEF_INIT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s0_valid,
    input  logic [DATA_W-1:0] s0_data,
    output logic              s0_ready,
    input  logic              s1_valid,
    input  logic [DATA_W-1:0] s1_data,
    output logic              s1_ready,
    output logic              crc_valid,
    input  logic              crc_ready,
    output logic [CRC_W-1:0]  crc_out,
    output logic              crc_src,
    output logic              busy
);

    localparam int               CNT_W    = clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   sh_q, sh_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                src_q, src_d;
    logic                last_q, last_d;

    logic                any_vld;
    logic                gnt;
    logic                accept;
    logic                shifting;
    logic [CRC_W-1:0]    lfsr_crc;

    // Arbiter: a lone requester always wins; on a tie the one not served last wins.
    // Reset gating keeps both readys low while reset is asserted.
    assign any_vld  = s0_valid | s1_valid;
    assign gnt      = (s0_valid & s1_valid) ? ~last_q : s1_valid;
    assign accept   = (state_q == IDLE) & any_vld & reset;
    assign s0_ready = accept & ~gnt;
    assign s1_ready = accept & gnt;
    assign shifting = (state_q == SHIFT);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        src_d   = src_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sh_d    = gnt ? s1_data : s0_data;
                    cnt_d   = '0;
                    src_d   = gnt;
                    last_d  = gnt;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sh_d = sh_q << 1;
                // Counter parks at the last index so it never wraps inside a message.
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (crc_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            sh_q    <= '0;
            cnt_q   <= '0;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    crc_lfsr_serial #(
        .CRC_W (CRC_W),
        .POLY  (POLY),
        .INIT  (INIT)
    ) u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .clr    (accept),
        .en     (shifting),
        .bit_in (sh_q[DATA_W-1]),
        .crc    (lfsr_crc)
    );

    // Outputs decode straight from state so a reset drops them without waiting for a clock.
    assign crc_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign crc_out   = crc_valid ? lfsr_crc : {CRC_W{1'b0}};
    assign crc_src   = src_q;

endmodule

// File: tb/tb_crc_serial_sched.sv
`timescale 1ns/1ps
module tb_crc_serial_sched;

    localparam int             DW  = 10;
    localparam int             CW  = 3;
    localparam logic [CW:0]    GEN = 4'b1011;   // x^3 + x + 1
    localparam logic [DW-1:0]  MSG_A = 10'b1010000011;
    localparam logic [DW-1:0]  MSG_B = 10'b1111000011;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s0_valid = 1'b0;
    logic [DW-1:0] s0_data = '0;
    logic          s0_ready;
    logic          s1_valid = 1'b0;
    logic [DW-1:0] s1_data = '0;
    logic          s1_ready;
    logic          crc_valid;
    logic          crc_ready = 1'b1;
    logic [CW-1:0] crc_out;
    logic          crc_src;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [CW-1:0] crc;
        logic          src;
        int            acc_cyc;
    } exp_t;
    exp_t sb[$];

    crc_serial_sched dut (
        .clk       (clk),
        .reset     (rst_n),
        .s0_valid  (s0_valid),
        .s0_data   (s0_data),
        .s0_ready  (s0_ready),
        .s1_valid  (s1_valid),
        .s1_data   (s1_data),
        .s1_ready  (s1_ready),
        .crc_valid (crc_valid),
        .crc_ready (crc_ready),
        .crc_out   (crc_out),
        .crc_src   (crc_src),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference remainder by polynomial long division of m * x^CW.
    function automatic logic [CW-1:0] crc_ref(input logic [DW-1:0] m);
        logic [DW+CW-1:0] r;
        r = {m, {CW{1'b0}}};
        for (int i = DW + CW - 1; i >= CW; i--) begin
            if (r[i]) r[i -: CW+1] = r[i -: CW+1] ^ GEN;
        end
        return r[CW-1:0];
    endfunction

    // Scoreboard: push on each accept handshake, check latency on crc_valid rise, pop on result handshake.
    logic prev_vld = 1'b0;
    exp_t e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (s0_valid && s0_ready) sb.push_back(exp_t'{crc_ref(s0_data), 1'b0, cyc});
            if (s1_valid && s1_ready) sb.push_back(exp_t'{crc_ref(s1_data), 1'b1, cyc});
            if (crc_valid && !prev_vld) begin
                n_checks++;
                if (sb.size() == 0)
                    $display("FAIL sb_latency: crc_valid rose with nothing outstanding");
                else if (cyc - sb[0].acc_cyc !== DW + 1)
                    $display("FAIL sb_latency: %0d edges from accept, required %0d", cyc - sb[0].acc_cyc - 1, DW);
                else
                    n_pass++;
            end
            if (crc_valid && crc_ready) begin
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL sb_unexpected: crc=%b src=%b with nothing outstanding", crc_out, crc_src);
                end else begin
                    e = sb.pop_front();
                    if (crc_out !== e.crc || crc_src !== e.src)
                        $display("FAIL sb_result: crc=%b src=%b, required crc=%b src=%b", crc_out, crc_src, e.crc, e.src);
                    else
                        n_pass++;
                end
            end
        end
        prev_vld = rst_n ? crc_valid : 1'b0;
    end

    task automatic do_reset();
        rst_n     = 1'b0;
        s0_valid  = 1'b0;
        s1_valid  = 1'b0;
        crc_ready = 1'b1;
        repeat (2) @(posedge clk);
        sb.delete();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!crc_valid && n < 40);
        n_checks++;
        if (!crc_valid) $display("FAIL %s_timeout: crc_valid=%b after %0d cycles, required 1", tag, crc_valid, n);
        else n_pass++;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 60);
        n_checks++;
        if (busy) $display("FAIL %s_idle_timeout: busy=%b after %0d cycles, required 0", tag, busy, n);
        else n_pass++;
    endtask

    task automatic test_reset();
        s0_valid = 1'b1;
        s1_valid = 1'b1;
        #12;
        n_checks++;
        if ({crc_valid, busy, crc_out, crc_src} !== 6'b0)
            $display("FAIL reset_outputs: valid=%b busy=%b out=%b src=%b, required all 0", crc_valid, busy, crc_out, crc_src);
        else n_pass++;
        n_checks++;
        if ({s0_ready, s1_ready} !== 2'b00)
            $display("FAIL reset_ready: s0_ready=%b s1_ready=%b, required 00", s0_ready, s1_ready);
        else n_pass++;
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) $display("FAIL reset_release_busy: busy=%b, required 0", busy);
        else n_pass++;
    endtask

    task automatic test_single(input logic src, input logic [DW-1:0] data, input logic [CW-1:0] exp_crc, input string tag);
        @(posedge clk); #1;
        if (src) begin s1_valid = 1'b1; s1_data = data; end
        else     begin s0_valid = 1'b1; s0_data = data; end
        @(negedge clk);
        n_checks++;
        if ((src ? s1_ready : s0_ready) !== 1'b1 || (src ? s0_ready : s1_ready) !== 1'b0)
            $display("FAIL %s_grant: s0_ready=%b s1_ready=%b, requester %0d required", tag, s0_ready, s1_ready, src);
        else n_pass++;
        @(posedge clk); #1;
        // Post-accept input changes must not affect the result.
        s0_valid = 1'b0; s1_valid = 1'b0;
        s0_data = ~data; s1_data = ~data;
        wait_vld(tag);
        n_checks++;
        if (crc_out !== exp_crc || crc_src !== src)
            $display("FAIL %s_result: crc=%b src=%b, required crc=%b src=%b", tag, crc_out, crc_src, exp_crc, src);
        else n_pass++;
        wait_idle(tag);
    endtask

    task automatic test_both();
        do_reset();
        @(posedge clk); #1;
        s0_valid = 1'b1; s0_data = MSG_A;
        s1_valid = 1'b1; s1_data = MSG_B;
        @(negedge clk);
        n_checks++;
        if ({s0_ready, s1_ready} !== 2'b10) $display("FAIL both_first_tie: s0/s1 ready=%b%b, required 10", s0_ready, s1_ready);
        else n_pass++;
        @(posedge clk); #1 s0_valid = 1'b0;
        wait_vld("both_s0");
        n_checks++;
        if (crc_out !== 3'b001 || crc_src !== 1'b0) $display("FAIL both_s0_result: crc=%b src=%b, required 001/0", crc_out, crc_src);
        else n_pass++;
        @(posedge clk); #1 s0_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({s0_ready, s1_ready} !== 2'b01) $display("FAIL both_rr_tie: s0/s1 ready=%b%b, required 01", s0_ready, s1_ready);
        else n_pass++;
        @(posedge clk); #1 s1_valid = 1'b0;
        wait_vld("both_s1");
        n_checks++;
        if (crc_out !== 3'b011 || crc_src !== 1'b1) $display("FAIL both_s1_result: crc=%b src=%b, required 011/1", crc_out, crc_src);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (s0_ready !== 1'b1) $display("FAIL both_s0_again: s0_ready=%b, required 1", s0_ready);
        else n_pass++;
        @(posedge clk); #1 s0_valid = 1'b0;
        wait_vld("both_s0b");
        wait_idle("both");
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        crc_ready = 1'b0;
        s0_valid = 1'b1; s0_data = MSG_A;
        @(posedge clk); #1 s0_valid = 1'b0;
        wait_vld("bp");
        @(posedge clk); #1;
        s0_valid = 1'b1; s0_data = MSG_B;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if ({crc_valid, crc_out, crc_src, s0_ready} !== 6'b1_001_0_0)
                $display("FAIL bp_hold_%0d: valid=%b out=%b src=%b s0_ready=%b, required 1/001/0/0", i, crc_valid, crc_out, crc_src, s0_ready);
            else n_pass++;
            @(posedge clk);
        end
        #1 crc_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (s0_ready !== 1'b0) $display("FAIL bp_ready_in_done: s0_ready=%b, required 0", s0_ready);
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (s0_ready !== 1'b1) $display("FAIL bp_accept_edge2: s0_ready=%b, required 1", s0_ready);
        else n_pass++;
        @(posedge clk); #1 s0_valid = 1'b0;
        wait_vld("bp2");
        n_checks++;
        if (crc_out !== 3'b011 || crc_src !== 1'b0) $display("FAIL bp2_result: crc=%b src=%b, required 011/0", crc_out, crc_src);
        else n_pass++;
        wait_idle("bp");
    endtask

    task automatic check_quiet(input string tag);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (crc_valid || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL %s_quiet: activity seen=%b, required 0", tag, seen);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        // Reset during SHIFT.
        @(posedge clk); #1;
        s0_valid = 1'b1; s0_data = MSG_A;
        @(posedge clk); #1 s0_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b1) $display("FAIL rst_shift_pre: busy=%b, required 1", busy);
        else n_pass++;
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || crc_valid !== 1'b0) $display("FAIL rst_shift_async: busy=%b valid=%b, required 0/0", busy, crc_valid);
        else n_pass++;
        sb.delete();
        @(posedge clk); @(posedge clk);
        #2 rst_n = 1'b1;
        check_quiet("rst_shift");
        // Reset during DONE.
        @(posedge clk); #1;
        crc_ready = 1'b0;
        s0_valid = 1'b1; s0_data = MSG_B;
        @(posedge clk); #1 s0_valid = 1'b0;
        wait_vld("rst_done");
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (crc_valid !== 1'b0 || crc_out !== 3'b000) $display("FAIL rst_done_async: valid=%b out=%b, required 0/000", crc_valid, crc_out);
        else n_pass++;
        sb.delete();
        @(posedge clk);
        #1 crc_ready = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b1;
        check_quiet("rst_done");
        test_single(1'b0, MSG_A, 3'b001, "rst_fresh");
    endtask

    task automatic test_drop();
        @(posedge clk); #1;
        s0_valid = 1'b1; s0_data = MSG_B;
        @(posedge clk); #1;
        s0_valid = 1'b0;
        s1_valid = 1'b1; s1_data = MSG_A;
        crc_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 s1_valid = 1'b0;
        crc_ready = 1'b1;
        wait_vld("drop");
        wait_idle("drop");
        check_quiet("drop");
    endtask

    task automatic test_back_to_back();
        int acc[$];
        int n;
        @(posedge clk); #1;
        crc_ready = 1'b1;
        s0_valid = 1'b1; s0_data = '0;
        n = 0;
        while (acc.size() < 4 && n < 80) begin
            @(negedge clk);
            n++;
            if (s0_ready) acc.push_back(cyc);
        end
        @(posedge clk); #1 s0_valid = 1'b0;
        n_checks++;
        if (acc.size() !== 4) $display("FAIL b2b_accepts: %0d accepts seen, required 4", acc.size());
        else n_pass++;
        for (int i = 1; i < acc.size(); i++) begin
            n_checks++;
            if (acc[i] - acc[i-1] !== DW + 2) $display("FAIL b2b_spacing_%0d: %0d cycles, required %0d", i, acc[i] - acc[i-1], DW + 2);
            else n_pass++;
        end
        wait_vld("b2b_last");
        n_checks++;
        if (crc_out !== 3'b000) $display("FAIL b2b_zero_crc: crc=%b, required 000", crc_out);
        else n_pass++;
        wait_idle("b2b");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single(1'b0, MSG_A, 3'b001, "s0_alone");
        test_single(1'b1, MSG_B, 3'b011, "s1_alone");
        test_both();
        test_backpressure();
        test_reset_mid();
        test_drop();
        test_back_to_back();
        repeat (2) @(negedge clk);
        n_checks++;
        if (sb.size() !== 0) $display("FAIL sb_leftover: %0d results outstanding, required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/crc_serial_sched.md
Name: crc_serial_sched

Overview:
- Two-requester scheduler that time-shares one bit-serial CRC LFSR engine.
- Arbitrates round-robin between two message sources and latches the winner's DATA_W-bit word.
- Shifts the word MSB-first into the LFSR over DATA_W cycles, then presents the CRC remainder with a valid/ready handshake.
- Sits between message producers and the CRC consumer, replacing free-running single-user serial CRC instances.

Parameters:
- DATA_W, 10: message width in bits.
- CRC_W, 3: CRC remainder width, equal to the generator degree.
- POLY, 3'b011: generator low-order coefficients. x^CRC_W is implicit; the default is x^3+x+1.
- INIT, 3'b000: LFSR value loaded at message accept.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately.
- s0_valid  in  1  requester 0 has a message.
- s0_data  in  DATA_W  requester 0 message.
- s0_ready  out  1  requester 0 accepted on this edge if s0_valid.
- s1_valid  in  1  requester 1 has a message.
- s1_data  in  DATA_W  requester 1 message.
- s1_ready  out  1  requester 1 accepted on this edge if s1_valid.
- crc_valid  out  1  crc_out and crc_src are valid.
- crc_ready  in  1  consumer accepts the result.
- crc_out  out  CRC_W  remainder of message·x^CRC_W mod generator.
- crc_src  out  1  index of the requester that owns crc_out.
- busy  out  1  high in the SHIFT or DONE state.

Behaviour:
- Reset values:
  - state=IDLE, shift register=0, counter=0, LFSR=INIT.
  - crc_valid=0, crc_out=0, crc_src=0, busy=0.
  - last_grant=1, so requester 0 wins the first tie.
  - s0_ready and s1_ready are forced 0 while reset is low.
- IDLE state:
  - Grant is combinational. If only one requester is valid, it is granted. If both are valid, grant goes to the requester that is not last_grant.
  - s_ready[g] = 1 only for the granted requester; both readys are 0 when neither is valid or state is not IDLE.
  - On valid&ready: latch data, load LFSR=INIT, counter=0, crc_src=g, last_grant=g, then go to SHIFT.
- SHIFT state:
  - Each cycle: fb = lfsr[CRC_W-1] ^ sh[DATA_W-1].
  - lfsr <= {lfsr[CRC_W-2:0],1'b0} ^ (fb ? POLY : 0).
  - sh <= sh<<1; counter++.
  - When counter==DATA_W-1, go to DONE on that edge.
- DONE state:
  - crc_valid=1; crc_out and crc_src are held stable until crc_ready.
  - On crc_ready, go to IDLE and drop crc_valid on the same edge.
- Timing:
  - Latency: crc_valid rises exactly DATA_W edges after the accept edge.
  - Back-to-back throughput: one message per DATA_W+2 cycles. No accept occurs while in DONE.
- Boundary conditions:
  - Input data changes after accept are ignored.
  - A request dropped before grant is never processed.
  - crc_ready asserted outside DONE has no effect.
  - Reset low mid-SHIFT or mid-DONE: partial result is discarded, crc_valid goes to 0 asynchronously, and nothing is replayed after release.
  - The counter saturates at DATA_W-1; it never wraps within a message.

Decomposition:
- Package crc_sched_pkg holds:
  - state enum {IDLE, SHIFT, DONE};
  - default DATA_W, CRC_W, POLY and INIT constants;
  - the counter-width function clog2(DATA_W).
- One sub-module, crc_lfsr_serial:
  - ports clk, reset, clr, en, bit_in, crc[CRC_W-1:0];
  - parameters CRC_W, POLY, INIT;
  - pure LFSR with no control logic.
- The scheduler owns the arbiter, FSM, shift register and counter.

Test Plan:
- Requester 0 alone, s0_data=10'b1010000011 -> accepted on the first edge; crc_valid rises 10 edges later with crc_out=3'b001, crc_src=0.
- Requester 1 alone, s1_data=10'b1111000011 -> crc_out=3'b011, crc_src=1.
- Both valid after reset with the two words above, crc_ready=1:
  - s0 is served first (001), then s1 (011).
  - Re-asserting both after the s0 result then serves s1 first (round-robin).
- crc_ready held low for 5 cycles in DONE:
  - crc_valid, crc_out and crc_src stay stable;
  - s0_ready and s1_ready stay 0 despite s0_valid=1;
  - the new message is accepted 2 edges after crc_ready rises.
- Reset driven low at SHIFT cycle 5 -> crc_valid and busy go to 0 immediately. After release, a fresh 10'b1010000011 yields 3'b001.
- Continuous s0_valid with data 10'b0000000000 and crc_ready=1 -> crc_out=3'b000 every time, with accepts spaced exactly 12 cycles apart.
